ram_fifo_ctrl: RTL and testbench

Single-clock synchronous FIFO controller for one AP3 `RAM` block used as a 32-bit simple dual-port memory. It sits directly upstream of the `RAM` macro: it owns the read/write pointers, occupancy count and status flags, and drives the macro's `WADDR/WDATA/WEN/RADDR/REN` ports. The fabric logic sees a push/pop interface instead of raw addresses.

---
 rtl/ram_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: push/pop FIFO controller in front of one 32-bit simple dual-port RAM block.
// Optional sticky overflow/underflow flags are built only when RAM_FIFO_ERR_EN is defined.
`default_nettype none

module ram_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 9,
  parameter int AE_LEVEL   = 4,
  parameter int AF_LEVEL   = 508
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [31:0]           push_data,
  input  logic                  pop,
  output logic [31:0]           pop_data,
  output logic                  pop_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [10:0]           ram_waddr,
  output logic [31:0]           ram_wdata,
  output logic                  ram_wen,
  output logic [10:0]           ram_raddr,
  output logic                  ram_ren,
  input  logic [31:0]           ram_rdata
);

  localparam logic [DEPTH_LOG2:0] c_FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic                c_AF_RST = (AF_LEVEL == 0);

  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almost_empty;
  logic                  r_almost_full;
  logic                  r_pop_valid;

  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic [DEPTH_LOG2:0]   w_count_next;
  logic [31:0]           w_count_next32;

  // rst_n gates the strobes so the macro sees no access while reset is held.
  assign w_push_acc = push & ~r_full  & ~flush & rst_n;
  assign w_pop_acc  = pop  & ~r_empty & ~flush & rst_n;

  assign w_count_next   = r_count + (DEPTH_LOG2+1)'(w_push_acc) - (DEPTH_LOG2+1)'(w_pop_acc);
  assign w_count_next32 = 32'(w_count_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= c_AF_RST;
      r_pop_valid    <= 1'b0;
    end else if (flush) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= c_AF_RST;
      r_pop_valid    <= 1'b0;
    end else begin
      if (w_push_acc) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop_acc)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_full         <= (w_count_next == c_FULL);
      r_almost_empty <= (w_count_next32 <= 32'(AE_LEVEL));
      r_almost_full  <= (w_count_next32 >= 32'(AF_LEVEL));
      r_pop_valid    <= w_pop_acc;
    end
  end

`ifdef RAM_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push && r_full)  r_overflow  <= 1'b1;
      if (pop  && r_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign ram_wen      = w_push_acc;
  assign ram_wdata    = push_data;
  assign ram_waddr    = {{(11-DEPTH_LOG2){1'b0}}, r_wptr};
  assign ram_ren      = w_pop_acc;
  assign ram_raddr    = {{(11-DEPTH_LOG2){1'b0}}, r_rptr};

  assign pop_data     = ram_rdata;
  assign pop_valid    = r_pop_valid;
  assign count        = r_count;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
// Directed self-checking bench for ram_fifo_ctrl at depth 16, with a behavioural RAM macro.
`default_nettype none

module tb_ram_fifo_ctrl;

`ifdef RAM_FIFO_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        push;
  logic [31:0] push_data;
  logic        pop;
  logic [31:0] pop_data;
  logic        pop_valid;
  logic [4:0]  count;
  logic        empty, full, almost_empty, almost_full;
  logic        overflow, underflow;
  logic [10:0] ram_waddr, ram_raddr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_wen, ram_ren;

  logic [31:0] mem [0:2047];
  logic [31:0] q[$];
  int          errors = 0;
  int          checks = 0;

  ram_fifo_ctrl #(.DEPTH_LOG2(4), .AE_LEVEL(2), .AF_LEVEL(14)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .push_data(push_data),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .count(count),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  task automatic drive(input logic p, input logic [31:0] d, input logic r, input logic f);
    @(negedge clk);
    push = p; push_data = d; pop = r; flush = f;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; push = 1'b1; push_data = 32'hDEAD; pop = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        count !== 5'd0 || pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: e=%b ae=%b f=%b af=%b cnt=%0d pv=%b required 1 1 0 0 0 0",
               empty, almost_empty, full, almost_full, count, pop_valid);
    end
    checks++;
    if (ram_wen !== 1'b0 || ram_ren !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: wen=%b ren=%b ov=%b un=%b required 0 0 0 0",
               ram_wen, ram_ren, overflow, underflow);
    end
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0);
      checks++;
      if (count !== 5'(i) || almost_full !== (i >= 14) || ram_wen !== 1'b1 || ram_waddr !== 11'(i)) begin
        errors++;
        $display("FAIL fill_%0d: cnt=%0d af=%b wen=%b waddr=%0d required %0d %b 1 %0d",
                 i, count, almost_full, ram_wen, ram_waddr, i, (i >= 14), i);
      end
    end
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || almost_full !== 1'b1 || ram_wen !== 1'b0) begin
      errors++;
      $display("FAIL fill_overpush: full=%b cnt=%0d af=%b wen=%b required 1 16 1 0",
               full, count, almost_full, ram_wen);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (overflow !== EXP_ERR || count !== 5'd16) begin
      errors++;
      $display("FAIL overflow: ov=%b cnt=%0d required %b 16", overflow, count, EXP_ERR);
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (ram_ren !== 1'b1 || ram_raddr !== 11'(i) || pop_valid !== (i > 0) ||
          (i > 0 && pop_data !== 32'(i - 1))) begin
        errors++;
        $display("FAIL drain_%0d: ren=%b raddr=%0d pv=%b data=%h required 1 %0d %b %h",
                 i, ram_ren, ram_raddr, pop_valid, pop_data, i, (i > 0), i - 1);
      end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (pop_valid !== 1'b1 || pop_data !== 32'hF || empty !== 1'b1 || count !== 5'd0 || ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL drain_last: pv=%b data=%h empty=%b cnt=%0d ren=%b required 1 f 1 0 0",
               pop_valid, pop_data, empty, count, ram_ren);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pop_valid !== 1'b0 || underflow !== EXP_ERR || overflow !== EXP_ERR) begin
      errors++;
      $display("FAIL underflow: pv=%b un=%b ov=%b required 0 %b %b",
               pop_valid, underflow, overflow, EXP_ERR, EXP_ERR);
    end
  endtask

  task automatic test_simul_empty;
    drive(1'b1, 32'hA5, 1'b1, 1'b0);
    checks++;
    if (ram_wen !== 1'b1 || ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty_strobes: wen=%b ren=%b required 1 0", ram_wen, ram_ren);
    end
    q.push_back(32'hA5);
    drive(1'b1, 32'hB0, 1'b0, 1'b0);
    q.push_back(32'hB0);
    checks++;
    if (count !== 5'd1 || pop_valid !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty_count: cnt=%0d pv=%b empty=%b required 1 0 0", count, pop_valid, empty);
    end
    drive(1'b1, 32'hB1, 1'b0, 1'b0);
    q.push_back(32'hB1);
  endtask

  task automatic test_wrap;
    logic [31:0] exp_d;
    logic [10:0] prev_waddr;
    logic        saw_wrap;
    saw_wrap   = 1'b0;
    prev_waddr = 11'd0;
    exp_d      = 32'h0;
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 32'h100 + 32'(k), 1'b1, 1'b0);
      checks++;
      if (count !== 5'd3 || ram_wen !== 1'b1 || ram_ren !== 1'b1 ||
          (k > 0 && (pop_valid !== 1'b1 || pop_data !== exp_d))) begin
        errors++;
        $display("FAIL wrap_%0d: cnt=%0d wen=%b ren=%b pv=%b data=%h required 3 1 1 1 %h",
                 k, count, ram_wen, ram_ren, pop_valid, pop_data, exp_d);
      end
      if (k > 0 && prev_waddr == 11'd15 && ram_waddr == 11'd0) saw_wrap = 1'b1;
      prev_waddr = ram_waddr;
      exp_d = q.pop_front();
      q.push_back(32'h100 + 32'(k));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pop_valid !== 1'b1 || pop_data !== exp_d || count !== 5'd3 || saw_wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end: pv=%b data=%h cnt=%0d wrap=%b required 1 %h 3 1",
               pop_valid, pop_data, count, saw_wrap, exp_d);
    end
  endtask

  task automatic test_simul_full;
    logic [31:0] exp_d;
    for (int k = 0; k < 13; k++) begin
      drive(1'b1, 32'h200 + 32'(k), 1'b0, 1'b0);
      q.push_back(32'h200 + 32'(k));
    end
    drive(1'b1, 32'h300, 1'b1, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || ram_wen !== 1'b0 || ram_ren !== 1'b1) begin
      errors++;
      $display("FAIL simul_full_strobes: full=%b cnt=%0d wen=%b ren=%b required 1 16 0 1",
               full, count, ram_wen, ram_ren);
    end
    exp_d = q.pop_front();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd15 || full !== 1'b0 || pop_valid !== 1'b1 || pop_data !== exp_d) begin
      errors++;
      $display("FAIL simul_full_after: cnt=%0d full=%b pv=%b data=%h required 15 0 1 %h",
               count, full, pop_valid, pop_data, exp_d);
    end
  endtask

  task automatic test_flush;
    repeat (8) drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd7 || overflow !== EXP_ERR || underflow !== EXP_ERR) begin
      errors++;
      $display("FAIL pre_flush: cnt=%0d ov=%b un=%b required 7 %b %b", count, overflow, underflow, EXP_ERR, EXP_ERR);
    end
    drive(1'b1, 32'h400, 1'b0, 1'b1);
    checks++;
    if (ram_wen !== 1'b0 || ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL flush_strobes: wen=%b ren=%b required 0 0", ram_wen, ram_ren);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        pop_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: cnt=%0d e=%b ae=%b f=%b af=%b pv=%b ov=%b un=%b required 0 1 1 0 0 0 0 0",
               count, empty, almost_empty, full, almost_full, pop_valid, overflow, underflow);
    end
    drive(1'b1, 32'h500, 1'b0, 1'b0);
    checks++;
    if (ram_wen !== 1'b1 || ram_waddr !== 11'd0) begin
      errors++;
      $display("FAIL flush_ptr: wen=%b waddr=%0d required 1 0", ram_wen, ram_waddr);
    end
    drive(1'b1, 32'h501, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd2 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL post_flush_count: cnt=%0d ae=%b required 2 1", count, almost_empty);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'h502, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d empty=%b ae=%b required 0 1 1", count, empty, almost_empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simul_empty();
    test_wrap();
    test_simul_full();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
